// File: rtl/inst_prefetch_buffer.sv
// Instruction prefetch buffer: sequential fetch into a small PC-tagged FIFO with redirect flush.
// Optional starvation counter enabled by defining PREFETCH_PERF_EN.
module inst_prefetch_buffer #(
    parameter int unsigned           DEPTH    = 32'd4,
    parameter int unsigned           XLEN     = 32'd32,
    parameter logic [XLEN-1:0]       RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    output logic [XLEN-1:0] o_Addr,
    output logic            o_Ren,
    input  logic [XLEN-1:0] i_Instruction,
    output logic            o_Valid,
    output logic [XLEN-1:0] o_Instruction,
    output logic [XLEN-1:0] o_Pc,
    input  logic            i_Ready,
    input  logic            i_Redirect,
    input  logic [XLEN-1:0] i_Target,
    input  logic            i_Halt
`ifdef PREFETCH_PERF_EN
    ,
    output logic [31:0]     o_StarveCnt
`endif
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 32'd1;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_FETCH = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   fetch_pc_q, fetch_pc_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d;
    logic              inflight_q, inflight_d;
    logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [XLEN-1:0]   instr_mem_q [DEPTH];
    logic [XLEN-1:0]   pc_mem_q    [DEPTH];

    logic              fetching_s;
    logic              room_s;
    logic              issue_s;
    logic              push_s;
    logic              pop_s;
    logic              valid_s;
    logic              unused_s;

    assign unused_s = ^i_Target[1:0];

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave idle once, then fetch forever
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: state_d = S_FETCH;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs and handshake decode; in-flight requests reserve FIFO space
    always_comb begin
        fetching_s = 1'b0;
        case (state_q)
            S_FETCH: fetching_s = 1'b1;
            S_IDLE:  fetching_s = 1'b0;
            default: fetching_s = 1'b0;
        endcase
        room_s  = (count_q + CW'(inflight_q)) < CW'(DEPTH);
        issue_s = fetching_s && !i_Halt && !i_Redirect && room_s;
        valid_s = (count_q != {CW{1'b0}}) && !i_Redirect;
        pop_s   = valid_s && i_Ready;
        push_s  = inflight_q && !i_Redirect;
    end

    assign o_Ren         = issue_s;
    assign o_Addr        = fetch_pc_q;
    assign o_Valid       = valid_s;
    assign o_Instruction = instr_mem_q[rd_ptr_q];
    assign o_Pc          = pc_mem_q[rd_ptr_q];

    // Fetch address and outstanding-request bookkeeping
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = issue_s;
        if (i_Redirect) begin
            fetch_pc_d = {i_Target[XLEN-1:2], 2'b00};
        end else if (issue_s) begin
            fetch_pc_d = fetch_pc_q + XLEN'(32'd4);
            req_pc_d   = fetch_pc_q;
        end else begin
            fetch_pc_d = fetch_pc_q;
        end
    end

    // Fetch registers
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    // FIFO pointers and occupancy; redirect flushes everything
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (i_Redirect) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage; cleared on reset so the head reads zero when empty
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                instr_mem_q[i] <= '0;
                pc_mem_q[i]    <= '0;
            end
        end else if (push_s) begin
            instr_mem_q[wr_ptr_q] <= i_Instruction;
            pc_mem_q[wr_ptr_q]    <= req_pc_q;
        end
    end

`ifdef PREFETCH_PERF_EN
    logic [31:0] starve_q, starve_d;
    logic        starve_s;

    // Starvation: core is ready but nothing is offered while fetching freely
    always_comb begin
        starve_d = starve_q;
        starve_s = fetching_s && i_Ready && !valid_s && !i_Redirect && !i_Halt;
        if (starve_s && (starve_q != 32'hFFFF_FFFF)) begin
            starve_d = starve_q + 32'd1;
        end else begin
            starve_d = starve_q;
        end
    end

    // Starvation counter register
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            starve_q <= 32'd0;
        end else begin
            starve_q <= starve_d;
        end
    end

    assign o_StarveCnt = starve_q;
`endif

endmodule

// File: tb/tb_inst_prefetch_buffer.sv
// Directed self-checking bench for inst_prefetch_buffer with a word-indexed memory model (mem[k] = k).
module tb_inst_prefetch_buffer;

    logic        i_clk;
    logic        i_rstn;
    logic [31:0] o_Addr;
    logic        o_Ren;
    logic [31:0] i_Instruction;
    logic        o_Valid;
    logic [31:0] o_Instruction;
    logic [31:0] o_Pc;
    logic        i_Ready;
    logic        i_Redirect;
    logic [31:0] i_Target;
    logic        i_Halt;

    int n_cmp;
    int n_err;

    inst_prefetch_buffer dut (
        .i_clk         (i_clk),
        .i_rstn        (i_rstn),
        .o_Addr        (o_Addr),
        .o_Ren         (o_Ren),
        .i_Instruction (i_Instruction),
        .o_Valid       (o_Valid),
        .o_Instruction (o_Instruction),
        .o_Pc          (o_Pc),
        .i_Ready       (i_Ready),
        .i_Redirect    (i_Redirect),
        .i_Target      (i_Target),
        .i_Halt        (i_Halt)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Synchronous instruction memory: word k holds value k
    always @(posedge i_clk) begin
        if (o_Ren) begin
            i_Instruction <= {2'b00, o_Addr[31:2]};
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        i_rstn = 1'b0;
        step();
        i_rstn = 1'b1;
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        i_rstn = 1'b0;
        i_Ready = 1'b1;
        i_Redirect = 1'b0;
        i_Target = 32'h0;
        i_Halt = 1'b0;
        i_Instruction = 32'h0;

        // Reset values
        step();
        chk("rst_ren",   {31'd0, o_Ren},   32'd0);
        chk("rst_valid", {31'd0, o_Valid}, 32'd0);
        chk("rst_addr",  o_Addr,           32'h0);
        chk("rst_instr", o_Instruction,    32'h0);
        chk("rst_pc",    o_Pc,             32'h0);

        // Startup latency, then one instruction per cycle
        i_rstn = 1'b1;
        #1;
        chk("c1_ren", {31'd0, o_Ren}, 32'd0);
        step();
        chk("c2_ren",  {31'd0, o_Ren}, 32'd1);
        chk("c2_addr", o_Addr,         32'h0);
        step();
        chk("c3_valid", {31'd0, o_Valid}, 32'd0);
        chk("c3_addr",  o_Addr,           32'h4);
        step();
        for (int i = 0; i < 3; i++) begin
            chk("stream_valid", {31'd0, o_Valid}, 32'd1);
            chk("stream_pc",    o_Pc,             32'(4 * i));
            chk("stream_instr", o_Instruction,    32'(i));
            step();
        end

        // Core stalled: FIFO fills to DEPTH and fetch stops
        i_Ready = 1'b0;
        do_reset();
        repeat (10) step();
        chk("full_ren",   {31'd0, o_Ren},   32'd0);
        chk("full_valid", {31'd0, o_Valid}, 32'd1);
        chk("full_pc",    o_Pc,             32'h0);
        i_Ready = 1'b1;
        #1;
        for (int i = 0; i < 8; i++) begin
            chk("drain_valid", {31'd0, o_Valid}, 32'd1);
            chk("drain_pc",    o_Pc,             32'(4 * i));
            chk("drain_instr", o_Instruction,    32'(i));
            if (i == 1) begin
                chk("drain_addr", o_Addr, 32'h10);
            end
            step();
        end

        // Redirect with two buffered entries and one request in flight
        i_Ready = 1'b0;
        do_reset();
        repeat (4) step();
        chk("pre_rd_valid", {31'd0, o_Valid}, 32'd1);
        chk("pre_rd_pc",    o_Pc,             32'h0);
        chk("pre_rd_addr",  o_Addr,           32'hC);
        i_Redirect = 1'b1;
        i_Target = 32'h103;
        #1;
        chk("rd_valid", {31'd0, o_Valid}, 32'd0);
        chk("rd_ren",   {31'd0, o_Ren},   32'd0);
        step();
        i_Redirect = 1'b0;
        i_Ready = 1'b1;
        #1;
        chk("post_rd_valid", {31'd0, o_Valid}, 32'd0);
        chk("post_rd_ren",   {31'd0, o_Ren},   32'd1);
        chk("post_rd_addr",  o_Addr,           32'h100);
        step();
        chk("post_rd_valid2", {31'd0, o_Valid}, 32'd0);
        step();
        chk("tgt_valid", {31'd0, o_Valid}, 32'd1);
        chk("tgt_pc",    o_Pc,             32'h100);
        chk("tgt_instr", o_Instruction,    32'h40);
        step();
        chk("tgt_pc2",    o_Pc,          32'h104);
        chk("tgt_instr2", o_Instruction, 32'h41);

        // Back-to-back redirects, last one wins; target wraps at the top of memory
        i_Redirect = 1'b1;
        i_Target = 32'h200;
        #1;
        chk("b2b_valid", {31'd0, o_Valid}, 32'd0);
        step();
        i_Target = 32'hFFFF_FFF8;
        step();
        i_Redirect = 1'b0;
        #1;
        chk("wrap_addr0", o_Addr,          32'hFFFF_FFF8);
        chk("wrap_ren0",  {31'd0, o_Ren},  32'd1);
        chk("wrap_v0",    {31'd0, o_Valid}, 32'd0);
        step();
        chk("wrap_addr1", o_Addr,           32'hFFFF_FFFC);
        chk("wrap_v1",    {31'd0, o_Valid}, 32'd0);
        step();
        chk("wrap_pc0",    o_Pc,          32'hFFFF_FFF8);
        chk("wrap_instr0", o_Instruction, 32'h3FFF_FFFE);
        chk("wrap_addr2",  o_Addr,        32'h0);
        step();
        chk("wrap_pc1",    o_Pc,          32'hFFFF_FFFC);
        chk("wrap_instr1", o_Instruction, 32'h3FFF_FFFF);
        step();
        chk("wrap_pc2",    o_Pc,          32'h0);
        chk("wrap_instr2", o_Instruction, 32'h0);

        // Halt: in-flight word lands, FIFO drains, fetch resumes where it stopped
        i_Halt = 1'b1;
        #1;
        chk("halt_ren",   {31'd0, o_Ren},   32'd0);
        chk("halt_valid", {31'd0, o_Valid}, 32'd1);
        step();
        chk("halt_pc", o_Pc,             32'h4);
        chk("halt_v",  {31'd0, o_Valid}, 32'd1);
        step();
        chk("halt_empty", {31'd0, o_Valid}, 32'd0);
        i_Halt = 1'b0;
        #1;
        chk("resume_ren",  {31'd0, o_Ren}, 32'd1);
        chk("resume_addr", o_Addr,         32'h8);
        step();
        chk("resume_empty", {31'd0, o_Valid}, 32'd0);
        step();
        chk("resume_pc",    o_Pc,          32'h8);
        chk("resume_instr", o_Instruction, 32'h2);

        // Asynchronous reset mid-stream with a full FIFO
        i_Ready = 1'b0;
        repeat (10) step();
        chk("areset_pre_valid", {31'd0, o_Valid}, 32'd1);
        #3;
        i_rstn = 1'b0;
        #1;
        chk("areset_valid", {31'd0, o_Valid}, 32'd0);
        chk("areset_ren",   {31'd0, o_Ren},   32'd0);
        chk("areset_addr",  o_Addr,           32'h0);
        i_rstn = 1'b1;
        i_Ready = 1'b1;
        step();
        chk("restart_ren",  {31'd0, o_Ren}, 32'd1);
        chk("restart_addr", o_Addr,         32'h0);
        step();
        step();
        chk("restart_valid", {31'd0, o_Valid}, 32'd1);
        chk("restart_pc",    o_Pc,             32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
